// File: rtl/slice_add_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor built on one SLICE-bit ripple chain.
// One slice is added per cycle, least-significant first, with the carry held
// in a register between slices. Ready/valid on both request and result sides.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand request handshake (a, b, cin, sub)
//   a, b            WIDTH-bit operands
//   cin             carry-in, add mode only
//   sub             1 = a-b, 0 = a+b+cin
//   out_valid/ready result handshake (sum, cout, overflow)
//   sum             WIDTH-bit result
//   cout            carry out of MSB (subtract: 1 = no borrow)
//   overflow        signed overflow
module slice_add_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned STEPS = WIDTH / SLICE;
  localparam int unsigned IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Reject parameter sets the slice chain cannot tile exactly.
  if ((WIDTH % SLICE) != 0 || SLICE == 0) begin : g_bad_params
    $error("slice_add_sequencer: WIDTH must be a non-zero multiple of SLICE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;     // already inverted for subtract
  logic              carry;
  logic [IDXW-1:0]   idx;

  int unsigned       off;
  logic [SLICE-1:0]  a_sl;
  logic [SLICE-1:0]  b_sl;
  logic [SLICE:0]    slice_res;
  logic              last;
  logic              slice_ovf;

  // One SLICE-bit full-adder chain, shared across all steps.
  assign off       = 32'(idx) * SLICE;
  assign a_sl      = a_q[off +: SLICE];
  assign b_sl      = b_q[off +: SLICE];
  assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry);
  assign last      = (idx == IDXW'(STEPS - 1));
  // Carry into the slice MSB is s^a^b at that bit; overflow XORs it with carry out.
  assign slice_ovf = slice_res[SLICE] ^ slice_res[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          sum[off +: SLICE] <= slice_res[SLICE-1:0];
          carry             <= slice_res[SLICE];
          if (last) begin
            cout      <= slice_res[SLICE];
            overflow  <= slice_ovf;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= S_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
